dispatch_queue: RTL and testbench

In-order dispatch buffer between decode/rename and the reservation stations. Holds decoded tasks, each tagged with its destination RS. Sends the head task to its RS when that RS reports not busy, as a registered one-cycle dispatch pulse, which the RS latches as its incoming task.

---
 rtl/dispatch_queue.sv | 131 +++++++++++++
 tb/tb_dispatch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order task dispatch buffer feeding reservation stations.
// Optional stall counter output STALL_CNT is enabled by defining DISPATCH_STATS_EN.
module dispatch_queue #(
  parameter int DEPTH  = 8,
  parameter int TASK_W = 128,
  parameter int TAG_W  = 3,
  parameter int NUM_RS = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       ENQ_VALID,
  input  logic [TASK_W-1:0]          ENQ_TASK,
  input  logic [TAG_W-1:0]           ENQ_RS,
  output logic                       ENQ_READY,
  input  logic [NUM_RS-1:0]          RS_BUSY,
  output logic                       DISPATCH_VALID,
  output logic [TASK_W-1:0]          DISPATCH_TASK,
  output logic [TAG_W-1:0]           DEST_RS,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       FULL,
  output logic                       EMPTY
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                STALL_CNT
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TASK_W-1:0] task_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              dv_q, dv_d;
  logic [TASK_W-1:0] task_q, task_d;
  logic [TAG_W-1:0]  dest_q, dest_d;
  logic [TAG_W-1:0]  shadow_q, shadow_d;

  logic              full, empty, enq, pop, eligible;
  logic [TAG_W-1:0]  head_tag;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_tag  = tag_mem[head_q];
  // Shadow tag blocks a second send to an RS whose busy flag has not caught up yet.
  assign eligible  = !empty && (head_tag != '0) && !RS_BUSY[head_tag] && (head_tag != shadow_q);
  assign pop       = eligible || (!empty && (head_tag == '0));
  assign enq       = ENQ_VALID && !full;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    dv_d     = 1'b0;
    task_d   = task_q;
    dest_d   = '0;
    shadow_d = '0;
    if (!FLUSH) begin
      if (enq) tail_d = tail_q + PW'(1);
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(pop);
      if (eligible) begin
        dv_d     = 1'b1;
        task_d   = task_mem[head_q];
        dest_d   = head_tag;
        shadow_d = head_tag;
      end
    end else begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dv_q     <= 1'b0;
      task_q   <= '0;
      dest_q   <= '0;
      shadow_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dv_q     <= dv_d;
      task_q   <= task_d;
      dest_q   <= dest_d;
      shadow_q <= shadow_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq && !FLUSH) begin
      task_mem[tail_q] <= ENQ_TASK;
      tag_mem[tail_q]  <= ENQ_RS;
    end
  end

  assign ENQ_READY      = !full;
  assign DISPATCH_VALID = dv_q;
  assign DISPATCH_TASK  = task_q;
  assign DEST_RS        = dest_q;
  assign COUNT          = count_q;
  assign FULL           = full;
  assign EMPTY          = empty;

`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (FLUSH) begin
      stall_d = '0;
    end else if (!empty && (head_tag != '0) && !eligible && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign STALL_CNT = stall_q;
`endif
endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - scoreboard bench for dispatch_queue with a queue-based reference model.
module tb_dispatch_queue;
  localparam int DEPTH = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         FLUSH = 1'b0;
  logic         ENQ_VALID = 1'b0;
  logic [127:0] ENQ_TASK = '0;
  logic [2:0]   ENQ_RS = '0;
  logic         ENQ_READY;
  logic [7:0]   RS_BUSY = '0;
  logic         DISPATCH_VALID;
  logic [127:0] DISPATCH_TASK;
  logic [2:0]   DEST_RS;
  logic [3:0]   COUNT;
  logic         FULL, EMPTY;
`ifdef DISPATCH_STATS_EN
  logic [31:0]  STALL_CNT;
`endif

  dispatch_queue #(.DEPTH(DEPTH), .TASK_W(128), .TAG_W(3), .NUM_RS(8)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .ENQ_VALID(ENQ_VALID), .ENQ_TASK(ENQ_TASK), .ENQ_RS(ENQ_RS), .ENQ_READY(ENQ_READY),
    .RS_BUSY(RS_BUSY),
    .DISPATCH_VALID(DISPATCH_VALID), .DISPATCH_TASK(DISPATCH_TASK), .DEST_RS(DEST_RS),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
`ifdef DISPATCH_STATS_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [127:0] t; logic [2:0] tag; } ent_t;
  typedef struct { int cyc; logic [2:0] tag; logic [127:0] t; } exp_t;

  ent_t        mq[$];
  exp_t        expq[$];
  logic [2:0]  shadow = '0;
  longint      stall_m = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every dispatch pulse against the oldest predicted one.
  always @(negedge CLK) begin
    if (!RST) begin
      if (DISPATCH_VALID) begin
        if (expq.size() == 0) begin
          chk("unexpected_dispatch", {125'd0, DEST_RS}, 128'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("dispatch_cycle", 128'(cyc), 128'(e.cyc));
          chk("dispatch_tag", {125'd0, DEST_RS}, {125'd0, e.tag});
          chk("dispatch_task", DISPATCH_TASK, e.t);
        end
      end else begin
        chk("idle_dest_rs", {125'd0, DEST_RS}, 128'd0);
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
          chk("missing_dispatch", 128'(0), {125'd0, expq[0].tag});
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic cycle(input logic fl, input logic ev, input logic [127:0] t,
                       input logic [2:0] tg, input logic [7:0] busy);
    int sz;
    logic [2:0] nsh;
    logic sent;
    ent_t h;
    ent_t n;
    FLUSH = fl; ENQ_VALID = ev; ENQ_TASK = t; ENQ_RS = tg; RS_BUSY = busy;
    sz = mq.size();
    nsh = '0;
    sent = 1'b0;
    if (fl) begin
      mq.delete();
      stall_m = 0;
    end else begin
      if (sz > 0) begin
        h = mq[0];
        if (h.tag == 0) begin
          void'(mq.pop_front());
        end else if (!busy[h.tag] && h.tag != shadow) begin
          void'(mq.pop_front());
          expq.push_back('{cyc + 1, h.tag, h.t});
          nsh = h.tag;
          sent = 1'b1;
        end
        if (h.tag != 0 && !sent && stall_m < 64'hFFFF_FFFF) stall_m++;
      end
      if (ev && sz < DEPTH) begin
        n.t = t; n.tag = tg;
        mq.push_back(n);
      end
    end
    shadow = nsh;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("count", 128'(COUNT), 128'(mq.size()));
    chk("full", 128'(FULL), 128'(mq.size() == DEPTH));
    chk("empty", 128'(EMPTY), 128'(mq.size() == 0));
    chk("enq_ready", 128'(ENQ_READY), 128'(mq.size() != DEPTH));
`ifdef DISPATCH_STATS_EN
    chk("stall_cnt", 128'(STALL_CNT), 128'(stall_m));
`endif
    FLUSH = 1'b0; ENQ_VALID = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    @(negedge CLK);
    #1;
    chk("rst_count", 128'(COUNT), 128'd0);
    chk("rst_empty", 128'(EMPTY), 128'd1);
    chk("rst_full", 128'(FULL), 128'd0);
    chk("rst_valid", 128'(DISPATCH_VALID), 128'd0);
    chk("rst_dest", {125'd0, DEST_RS}, 128'd0);
    chk("rst_task", DISPATCH_TASK, 128'd0);
    RST = 1'b0;

    // single task, one-cycle latency
    cycle(0, 1, 128'hA, 3'd2, 8'h00);
    cycle(0, 0, '0, 3'd0, 8'h00);
    cycle(0, 0, '0, 3'd0, 8'h00);

    // fill with all RS busy, ninth offer ignored, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 128'h100 + 128'(i), 3'(i % 7 + 1), 8'hFF);
    cycle(0, 1, 128'hDEAD, 3'd1, 8'hFF);
    for (int i = 0; i < DEPTH + 3; i++) cycle(0, 0, '0, 3'd0, 8'h00);

    // same-RS back-to-back is spaced by the shadow tag
    cycle(0, 1, 128'h31, 3'd3, 8'h00);
    cycle(0, 1, 128'h32, 3'd3, 8'h00);
    cycle(0, 1, 128'h41, 3'd4, 8'h00);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 3'd0, 8'h00);

    // invalid-tag head dropped silently
    cycle(0, 1, 128'h0BAD, 3'd0, 8'h00);
    cycle(0, 1, 128'h55, 3'd5, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 3'd0, 8'h00);

    // flush with a simultaneous enqueue
    for (int i = 0; i < 5; i++) cycle(0, 1, rnd128(), 3'(i + 1), 8'hFF);
    cycle(1, 1, 128'hF00D, 3'd6, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 3'd0, 8'h00);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rnd128(),
            3'($urandom_range(0, 7)), 8'($urandom & $urandom));
    end
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 3'd0, 8'h00);
    chk("drained_scoreboard", 128'(expq.size()), 128'd0);

    // asynchronous reset between edges while a pulse is showing
    cycle(0, 1, 128'h11, 3'd1, 8'hFF);
    cycle(0, 1, 128'h22, 3'd2, 8'hFF);
    cycle(0, 1, 128'h33, 3'd3, 8'hFF);
    cycle(0, 0, '0, 3'd0, 8'h00);
    chk("pre_rst_valid", 128'(DISPATCH_VALID), 128'd1);
    RST = 1'b1;
    #1;
    chk("async_rst_valid", 128'(DISPATCH_VALID), 128'd0);
    chk("async_rst_dest", {125'd0, DEST_RS}, 128'd0);
    chk("async_rst_task", DISPATCH_TASK, 128'd0);
    chk("async_rst_count", 128'(COUNT), 128'd0);
    chk("async_rst_empty", 128'(EMPTY), 128'd1);
    mq.delete();
    expq.delete();
    shadow = '0;
    stall_m = 0;
    @(negedge CLK);
    #1;
    RST = 1'b0;

    // head blocked for ten cycles
    cycle(0, 1, 128'h66, 3'd6, 8'h40);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 3'd0, 8'h40);
`ifdef DISPATCH_STATS_EN
    chk("stall_ten", 128'(STALL_CNT), 128'd10);
`endif
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 3'd0, 8'h00);
    chk("final_scoreboard", 128'(expq.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
